// File: rtl/wave_pwm_output_if.sv
// Sample handshake between the sine generator (master) and the PWM output stage (slave).
interface wave_pwm_output_if #(
    parameter int N_FRAC = 7
);
    logic signed [N_FRAC:0] data_i;
    logic                   data_valid_strobe_i;
    logic                   next_data_strobe_o;

    modport master (
        output data_i,
        output data_valid_strobe_i,
        input  next_data_strobe_o
    );

    modport slave (
        input  data_i,
        input  data_valid_strobe_i,
        output next_data_strobe_o
    );
endinterface

// File: rtl/wave_pwm_output.sv
// PWM output stage: double-buffers signed samples, converts them to offset-binary duty,
// drives a 2^W-cycle PWM pin and requests the next sample once per period.
module wave_pwm_output #(
    parameter int N_FRAC = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    wave_pwm_output_if.slave smp,
    output logic             pwm_o,
    output logic             underrun_o
);
    localparam int W = N_FRAC + 1;
    localparam logic [W-1:0] CNT_LAST = {W{1'b1}};
    localparam logic [W-1:0] MIDSCALE = {1'b1, {(W-1){1'b0}}};

    // Adding half-scale modulo 2^W is the same as flipping the sign bit.
    function automatic logic [W-1:0] to_offset_binary(input logic signed [W-1:0] s);
        return s ^ MIDSCALE;
    endfunction

    logic         en_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic         pending_q, pending_d;
    logic [W-1:0] duty_q, duty_d;
    logic         req_q, req_d;
    logic         underrun_q, underrun_d;

    logic [W-1:0] sample_duty;
    logic         strobe;
    logic         boundary;

    always_comb begin
        strobe      = smp.data_valid_strobe_i;
        sample_duty = to_offset_binary(smp.data_i);
        boundary    = en_q & (cnt_q == CNT_LAST);

        cnt_d      = en_q ? cnt_q + 1'b1 : '0;
        shadow_d   = strobe ? sample_duty : shadow_q;
        pending_d  = pending_q | strobe;
        duty_d     = duty_q;
        underrun_d = underrun_q;

        // A strobe landing on the boundary bypasses the shadow so it is not lost.
        if (boundary) begin
            pending_d = 1'b0;
            if (strobe) begin
                duty_d = sample_duty;
            end else if (pending_q) begin
                duty_d = shadow_q;
            end else begin
                underrun_d = 1'b1;
            end
        end

        req_d = enable_i & (~en_q | (cnt_q == CNT_LAST));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            en_q       <= 1'b0;
            cnt_q      <= '0;
            shadow_q   <= MIDSCALE;
            pending_q  <= 1'b0;
            duty_q     <= MIDSCALE;
            req_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            en_q       <= enable_i;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            duty_q     <= duty_d;
            req_q      <= req_d;
            underrun_q <= underrun_d;
        end
    end

    assign pwm_o                  = en_q & (cnt_q < duty_q);
    assign smp.next_data_strobe_o = req_q;
    assign underrun_o             = underrun_q;
endmodule

// File: tb/tb_wave_pwm_output.sv
// Bench for wave_pwm_output: period-level reference model (high-cycle count per period,
// request spacing, sticky underrun) driven with randomized samples and answer delays.
module tb_wave_pwm_output;
    localparam int N_FRAC = 7;
    localparam int W = N_FRAC + 1;
    localparam int P = 1 << W;

    logic clk;
    logic rst;
    logic enable;
    logic pwm;
    logic underrun;

    wave_pwm_output_if #(.N_FRAC(N_FRAC)) bus ();

    wave_pwm_output #(.N_FRAC(N_FRAC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .smp        (bus),
        .pwm_o      (pwm),
        .underrun_o (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int passed;
    int model_duty;
    bit model_und;

    function automatic int conv(input int v);
        return ((v % P) + P + P / 2) % P;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        bus.data_valid_strobe_i = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        model_duty = P / 2;
        model_und = 1'b0;
    endtask

    // Runs one period starting in a request cycle, optionally answering with up to two samples.
    task automatic measure(input int n, input int d1, input int v1, input int d2, input int v2,
                           output int hi, output int len, output int bad);
        bit seen_low;
        int i;
        hi = 0;
        bad = 0;
        seen_low = 1'b0;
        i = 0;
        len = 0;
        while (i < 600) begin
            if (pwm === 1'b1) begin
                hi++;
                if (seen_low) bad++;
            end else begin
                seen_low = 1'b1;
            end
            bus.data_valid_strobe_i = 1'b0;
            if (n >= 1 && i == d1) begin
                bus.data_valid_strobe_i = 1'b1;
                bus.data_i = v1[W-1:0];
            end
            if (n >= 2 && i == d2) begin
                bus.data_valid_strobe_i = 1'b1;
                bus.data_i = v2[W-1:0];
            end
            cyc();
            i++;
            if (bus.next_data_strobe_o === 1'b1) break;
        end
        len = i;
        bus.data_valid_strobe_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        bus.data_valid_strobe_i = 1'b0;
        bus.data_i = '0;
        repeat (3) cyc();
        rst = 1'b1;
        model_duty = P / 2;
        model_und = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++; if (pwm !== 1'b0) $display("FAIL reset_pwm cycle %0d got %b want 0", k, pwm); else passed++;
            checks++; if (bus.next_data_strobe_o !== 1'b0) $display("FAIL reset_req cycle %0d got %b want 0", k, bus.next_data_strobe_o); else passed++;
            checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun cycle %0d got %b want 0", k, underrun); else passed++;
        end
    endtask

    task automatic test_duty_mapping();
        int vals[5];
        int hi, len, bad;
        vals[0] = 0;
        vals[1] = -128;
        vals[2] = 127;
        vals[3] = int'($urandom_range(0, P - 1)) - P / 2;
        vals[4] = int'($urandom_range(0, P - 1)) - P / 2;
        enable = 1'b1;
        cyc();
        checks++; if (bus.next_data_strobe_o !== 1'b1) $display("FAIL map_first_req got %b want 1", bus.next_data_strobe_o); else passed++;
        for (int k = 0; k < 5; k++) begin
            measure(1, 5, vals[k], 0, 0, hi, len, bad);
            checks++; if (hi !== model_duty) $display("FAIL map_high period %0d got %0d want %0d", k, hi, model_duty); else passed++;
            checks++; if (len !== P) $display("FAIL map_period period %0d got %0d want %0d", k, len, P); else passed++;
            checks++; if (bad !== 0) $display("FAIL map_contig period %0d got %0d want 0", k, bad); else passed++;
            model_duty = conv(vals[k]);
            checks++; if (underrun !== model_und) $display("FAIL map_underrun period %0d got %b want %b", k, underrun, model_und); else passed++;
        end
    endtask

    task automatic test_underrun();
        int hi, len, bad, r;
        measure(1, 5, 64, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL und_pre got %0d want %0d", hi, model_duty); else passed++;
        model_duty = conv(64);
        measure(0, 0, 0, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL und_high got %0d want %0d", hi, model_duty); else passed++;
        model_und = 1'b1;
        checks++; if (underrun !== model_und) $display("FAIL und_set got %b want %b", underrun, model_und); else passed++;
        r = int'($urandom_range(0, P - 1)) - P / 2;
        measure(1, int'($urandom_range(0, P - 1)), r, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL und_repeat got %0d want %0d", hi, model_duty); else passed++;
        model_duty = conv(r);
        checks++; if (underrun !== model_und) $display("FAIL und_sticky got %b want %b", underrun, model_und); else passed++;
        measure(1, 5, r, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL und_recover got %0d want %0d", hi, model_duty); else passed++;
        checks++; if (underrun !== model_und) $display("FAIL und_sticky2 got %b want %b", underrun, model_und); else passed++;
    endtask

    task automatic test_coincident();
        int hi, len, bad, r;
        do_reset();
        enable = 1'b1;
        cyc();
        checks++; if (bus.next_data_strobe_o !== 1'b1) $display("FAIL coin_first_req got %b want 1", bus.next_data_strobe_o); else passed++;
        r = -64;
        for (int k = 0; k < 4; k++) begin
            measure(1, P - 1, r, 0, 0, hi, len, bad);
            checks++; if (hi !== model_duty) $display("FAIL coin_high period %0d got %0d want %0d", k, hi, model_duty); else passed++;
            checks++; if (len !== P) $display("FAIL coin_period period %0d got %0d want %0d", k, len, P); else passed++;
            model_duty = conv(r);
            checks++; if (underrun !== model_und) $display("FAIL coin_underrun period %0d got %b want %b", k, underrun, model_und); else passed++;
            r = int'($urandom_range(0, P - 1)) - P / 2;
        end
    endtask

    task automatic test_overwrite_enable();
        int hi, len, bad, req_seen;
        measure(2, 10, 10, 30, 20, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL ovw_pre got %0d want %0d", hi, model_duty); else passed++;
        model_duty = conv(20);
        measure(1, 5, 20, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL ovw_high got %0d want %0d", hi, model_duty); else passed++;
        repeat (100) cyc();
        enable = 1'b0;
        cyc();
        req_seen = 0;
        for (int k = 0; k < 7; k++) begin
            checks++; if (pwm !== 1'b0) $display("FAIL dis_pwm cycle %0d got %b want 0", k, pwm); else passed++;
            if (bus.next_data_strobe_o === 1'b1) req_seen++;
            cyc();
        end
        checks++; if (req_seen !== 0) $display("FAIL dis_req got %0d want 0", req_seen); else passed++;
        enable = 1'b1;
        cyc();
        checks++; if (bus.next_data_strobe_o !== 1'b1) $display("FAIL reen_req got %b want 1", bus.next_data_strobe_o); else passed++;
        measure(1, 5, 20, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL reen_high got %0d want %0d", hi, model_duty); else passed++;
        checks++; if (len !== P) $display("FAIL reen_period got %0d want %0d", len, P); else passed++;
    endtask

    task automatic test_reset_mid();
        int hi, len, bad;
        repeat (5) cyc();
        bus.data_valid_strobe_i = 1'b1;
        bus.data_i = W'($urandom_range(0, P - 1));
        cyc();
        bus.data_valid_strobe_i = 1'b0;
        repeat (44) cyc();
        do_reset();
        checks++; if (pwm !== 1'b0) $display("FAIL rmid_pwm got %b want 0", pwm); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL rmid_underrun got %b want 0", underrun); else passed++;
        enable = 1'b1;
        cyc();
        checks++; if (bus.next_data_strobe_o !== 1'b1) $display("FAIL rmid_req got %b want 1", bus.next_data_strobe_o); else passed++;
        measure(0, 0, 0, 0, 0, hi, len, bad);
        checks++; if (hi !== model_duty) $display("FAIL rmid_high got %0d want %0d", hi, model_duty); else passed++;
        model_und = 1'b1;
        checks++; if (underrun !== model_und) $display("FAIL rmid_discard got %b want %b", underrun, model_und); else passed++;
    endtask

    task automatic test_random();
        int hi, len, bad, n, d1, d2, v1, v2;
        for (int k = 0; k < 12; k++) begin
            n = int'($urandom_range(0, 6));
            if (n > 2) n = (n > 4) ? 2 : 1;
            d1 = int'($urandom_range(0, 200));
            d2 = int'($urandom_range(d1 + 1, P - 1));
            v1 = int'($urandom_range(0, P - 1)) - P / 2;
            v2 = int'($urandom_range(0, P - 1)) - P / 2;
            measure(n, d1, v1, d2, v2, hi, len, bad);
            checks++; if (hi !== model_duty) $display("FAIL rnd_high period %0d got %0d want %0d", k, hi, model_duty); else passed++;
            checks++; if (len !== P) $display("FAIL rnd_period period %0d got %0d want %0d", k, len, P); else passed++;
            checks++; if (bad !== 0) $display("FAIL rnd_contig period %0d got %0d want 0", k, bad); else passed++;
            if (n == 0) model_und = 1'b1;
            else model_duty = conv((n == 2) ? v2 : v1);
            checks++; if (underrun !== model_und) $display("FAIL rnd_underrun period %0d got %b want %b", k, underrun, model_und); else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b0;
        enable = 1'b0;
        bus.data_i = '0;
        bus.data_valid_strobe_i = 1'b0;
        test_reset();
        test_duty_mapping();
        test_underrun();
        test_coincident();
        test_overwrite_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
